// File: rtl/odd_div_if.sv
// rtl/odd_div_if.sv - observation bundle for the odd-ratio clock divider
`timescale 1ns/1ps

interface odd_div_if #(
    parameter int W = 8
);
    logic [W-1:0] cnt_pos;
    logic [W-1:0] cnt_neg;
    logic [W-1:0] cnt_temp;
    logic [W-1:0] cnt;
    logic         clk_out_pos;
    logic         clk_out_neg;
    logic         clk_out;

    // Divider side drives everything.
    modport master (
        output cnt_pos, cnt_neg, cnt_temp, cnt,
        output clk_out_pos, clk_out_neg, clk_out
    );

    // Observer side (slow-domain consumer or bench).
    modport slave (
        input cnt_pos, cnt_neg, cnt_temp, cnt,
        input clk_out_pos, clk_out_neg, clk_out
    );
endinterface

// File: rtl/odd_div.sv
// rtl/odd_div.sv - latch-free 50% duty odd-ratio clock divider, f_clk/N
`timescale 1ns/1ps

module odd_div #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst_n,    // active-high synchronous reset
    odd_div_if.master obs
);

    // Reject ratios the two-phase scheme cannot produce at 50% duty.
    if ((N % 2) == 0 || N < 3) begin : g_bad_n
        $error("odd_div: N must be odd and >= 3");
    end
    if ((2 * N - 1) >= (1 << W)) begin : g_bad_w
        $error("odd_div: W too narrow for phase index 2*N-1");
    end

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] HALF = W'((N - 1) / 2);
    localparam logic [W-1:0] TOP  = W'(2 * N - 1);

    logic [W-1:0] cnt_pos_q;
    logic [W-1:0] cnt_neg_q;
    logic         pos_q;
    logic         neg_q;
    logic [W-1:0] cnt_temp_c;
    logic [W-1:0] cnt_c;

    // Rising-edge modulo-N counter and the (N-1)/2-cycle-wide high pulse.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_pos_q <= '0;
            pos_q     <= 1'b0;
        end else begin
            cnt_pos_q <= (cnt_pos_q == LAST) ? '0 : cnt_pos_q + 1'b1;
            pos_q     <= (cnt_pos_q < HALF);
        end
    end

    // Falling-edge shadow: stretches the pulse by half a source period.
    always_ff @(negedge clk) begin
        if (rst_n) begin
            cnt_neg_q <= '0;
            neg_q     <= 1'b0;
        end else begin
            cnt_neg_q <= cnt_pos_q;
            neg_q     <= pos_q;
        end
    end

    // Half-period phase index: equal counters mean the falling edge has caught up.
    always_comb begin
        cnt_temp_c = {cnt_pos_q[W-2:0], 1'b0};
        cnt_c      = cnt_temp_c;
        if (cnt_pos_q != cnt_neg_q) begin
            cnt_c = (cnt_temp_c == '0) ? TOP : cnt_temp_c - 1'b1;
        end
    end

    assign obs.cnt_pos     = cnt_pos_q;
    assign obs.cnt_neg     = cnt_neg_q;
    assign obs.cnt_temp    = cnt_temp_c;
    assign obs.cnt         = cnt_c;
    assign obs.clk_out_pos = pos_q;
    assign obs.clk_out_neg = neg_q;
    // OR of two flop outputs; never both changing on the same edge.
    assign obs.clk_out     = pos_q | neg_q;

endmodule

// File: tb/tb_odd_div.sv
// tb/tb_odd_div.sv - randomized self-checking bench for odd_div, N = 3,5,7,9
`timescale 1ns/1ps

module tb_odd_div;

    localparam int W  = 8;
    localparam int ND = 4;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    logic [W-1:0] cp  [ND];
    logic [W-1:0] cn  [ND];
    logic [W-1:0] ct  [ND];
    logic [W-1:0] cx  [ND];
    logic         op  [ND];
    logic         on  [ND];
    logic         oc  [ND];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int NN = 3 + 2 * g;

        odd_div_if #(.W(W)) u_if ();

        odd_div #(.N(NN), .W(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .obs   (u_if.master)
        );

        assign cp[g] = u_if.cnt_pos;
        assign cn[g] = u_if.cnt_neg;
        assign ct[g] = u_if.cnt_temp;
        assign cx[g] = u_if.cnt;
        assign op[g] = u_if.clk_out_pos;
        assign on[g] = u_if.clk_out_neg;
        assign oc[g] = u_if.clk_out;

        realtime t_rise;
        realtime t_prev;
        realtime t_fall;
        int      n_rise;

        // Edge timestamps of the divided clock; rise count restarts at reset.
        always @(posedge u_if.clk_out or posedge rst_n) begin
            if (rst_n) begin
                n_rise = 0;
            end else begin
                t_prev = t_rise;
                t_rise = $realtime;
                n_rise++;
            end
        end

        // Most recent falling edge of the divided clock.
        always @(negedge u_if.clk_out) begin
            t_fall = $realtime;
        end

        task automatic duty_check();
            int hi_lo;
            chk($sformatf("n%0d_two_rises", NN), int'(n_rise >= 2), 1);
            if (n_rise >= 2) begin
                chk($sformatf("n%0d_period_ns", NN), int'(t_rise - t_prev), NN * 20);
                hi_lo = (t_fall > t_rise) ? int'(t_fall - t_rise) : int'(t_rise - t_fall);
                chk($sformatf("n%0d_half_ns", NN), hi_lo, NN * 10);
            end
        endtask
    end

    // e = number of clk edges seen since reset release (0 while in reset).
    task automatic check_all(input int e);
        int n, p, q, ph;
        for (int g = 0; g < ND; g++) begin
            n  = 3 + 2 * g;
            p  = (e + 1) / 2;
            q  = e / 2;
            ph = e % (2 * n);
            chk($sformatf("n%0d_cnt_pos e=%0d", n, e), int'(cp[g]), p % n);
            chk($sformatf("n%0d_cnt_neg e=%0d", n, e), int'(cn[g]), q % n);
            chk($sformatf("n%0d_cnt_temp e=%0d", n, e), int'(ct[g]), (2 * (p % n)) % 256);
            chk($sformatf("n%0d_cnt e=%0d", n, e), int'(cx[g]), ph);
            chk($sformatf("n%0d_clk_out_pos e=%0d", n, e), int'(op[g]),
                int'(p >= 1 && ((p - 1) % n) < (n - 1) / 2));
            chk($sformatf("n%0d_clk_out_neg e=%0d", n, e), int'(on[g]),
                int'(q >= 1 && ((q - 1) % n) < (n - 1) / 2));
            chk($sformatf("n%0d_clk_out e=%0d", n, e), int'(oc[g]),
                int'(ph >= 1 && ph <= n));
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        int e;
        int len;
        int rlen;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all(0);

        for (int run = 0; run < 6; run++) begin
            rst_n = 1'b0;
            e     = 0;
            len   = $urandom_range(30, 60);
            for (int i = 0; i < len; i++) begin
                @(posedge clk);
                #1;
                e++;
                check_all(e);
                @(negedge clk);
                #1;
                e++;
                check_all(e);
            end
            g_dut[0].duty_check();
            g_dut[1].duty_check();
            g_dut[2].duty_check();
            g_dut[3].duty_check();

            rst_n = 1'b1;
            rlen  = $urandom_range(1, 3);
            for (int r = 0; r < rlen; r++) begin
                @(posedge clk);
                @(negedge clk);
                #1;
                check_all(0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
